conv_accum_ctrl: RTL and testbench

//  Sequencer for the sign-magnitude Q-format sequential adder in the convolution datapath.
//  - Accepts a stream of product terms (one per cycle max) and drives the adder's en_add/local_reset.
//  - Feeds back the running sum, counts terms up to a per-window total and presents the final window sum.
//  - Sits between the multiplier array output and the output/activation stage.

---
 rtl/conv_accum_ctrl_if.sv | 16 +
 rtl/conv_accum_ctrl.sv | 103 ++++++++++
 tb/tb_conv_accum_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_accum_ctrl_if.sv
// Term-stream and window-result handshake bundle for conv_accum_ctrl.
// master = producer/consumer side, slave = the sequencer.
interface conv_accum_ctrl_if #(parameter int N = 32);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_ovf;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_ovf);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_ovf);
endinterface

// File: rtl/conv_accum_ctrl.sv
// Sequencer for the sign-magnitude sequential adder: clears it, streams one window of terms, presents the sum.
// Define ACCUM_RELU_EN to clamp negative window sums to zero on out_data.
module conv_accum_ctrl #(
  parameter int N     = 32,
  parameter int Q     = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  conv_accum_ctrl_if.slave bus,
  output logic             add_en,
  output logic             add_clr,
  output logic [N-1:0]     add_in1,
  output logic [N-1:0]     add_in2,
  input  logic [N-1:0]     add_sum,
  input  logic             add_ovf,
  output logic             busy
);

  // Q is only carried through; it just has to fit inside the magnitude field.
  if (Q > N - 1) begin : g_q_chk
    $error("conv_accum_ctrl: Q must not exceed N-1");
  end

  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] num_lat;
  logic             in_rdy;
  logic             out_vld;
  logic             ovf_flag;
  logic             en_d;

  assign add_en       = bus.in_valid & in_rdy;
  assign add_in1      = bus.in_data;
  assign add_in2      = add_sum;
  assign bus.in_ready = in_rdy;
  assign bus.out_valid = out_vld;
  // The last term's overflow shows up in the first DONE cycle, before it reaches ovf_flag.
  assign bus.out_ovf  = out_vld & (ovf_flag | (en_d & add_ovf));

`ifdef ACCUM_RELU_EN
  assign bus.out_data = add_sum[N-1] ? '0 : add_sum;
`else
  assign bus.out_data = add_sum;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      count    <= '0;
      num_lat  <= '0;
      in_rdy   <= 1'b0;
      add_clr  <= 1'b0;
      out_vld  <= 1'b0;
      busy     <= 1'b0;
      ovf_flag <= 1'b0;
      en_d     <= 1'b0;
    end else begin
      en_d <= add_en;
      // Adder overflow is stale except right after an add, so sample it only then.
      if (en_d && add_ovf) ovf_flag <= 1'b1;
      case (state)
        IDLE: if (start) begin
          num_lat  <= num_terms;
          count    <= '0;
          ovf_flag <= 1'b0;
          add_clr  <= 1'b1;
          busy     <= 1'b1;
          state    <= CLEAR;
        end
        CLEAR: begin
          add_clr <= 1'b0;
          if (num_lat == '0) begin
            out_vld <= 1'b1;
            state   <= DONE;
          end else begin
            in_rdy <= 1'b1;
            state  <= ACCUM;
          end
        end
        ACCUM: if (add_en) begin
          count <= count + CNT_W'(1);
          if (count == num_lat - CNT_W'(1)) begin
            in_rdy  <= 1'b0;
            out_vld <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          out_vld <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_accum_ctrl.sv
// Bench for conv_accum_ctrl with a behavioural sign-magnitude adder and a result scoreboard.
module tb_conv_accum_ctrl;
  localparam int N = 32, Q = 16, CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_terms = '0;
  logic             add_en, add_clr, busy;
  logic [N-1:0]     add_in1, add_in2;
  logic [N-1:0]     a_sum = '0;
  logic             a_ovf = 1'b0;

  typedef struct { logic [N-1:0] data; logic ovf; } res_t;
  res_t exp_q[$];
  int   checks = 0, errors = 0, en_cnt = 0;

  conv_accum_ctrl_if #(.N(N)) bus ();

  conv_accum_ctrl #(.N(N), .Q(Q), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_terms(num_terms), .bus(bus),
    .add_en(add_en), .add_clr(add_clr), .add_in1(add_in1), .add_in2(add_in2),
    .add_sum(a_sum), .add_ovf(a_ovf), .busy(busy));

  always #5 clk = ~clk;

  // Sign-magnitude add: {overflow, sum}.
  function automatic logic [N:0] sm_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] m;
    logic s;
    if (a[N-1] == b[N-1]) begin
      m = {1'b0, a[N-2:0]} + {1'b0, b[N-2:0]}; s = a[N-1];
    end else if (a[N-2:0] >= b[N-2:0]) begin
      m = {1'b0, a[N-2:0] - b[N-2:0]}; s = a[N-1];
    end else begin
      m = {1'b0, b[N-2:0] - a[N-2:0]}; s = b[N-1];
    end
    if (m[N-2:0] == '0) s = 1'b0;
    return {m[N-1], s, m[N-2:0]};
  endfunction

  function automatic logic [N-1:0] exp_out(input logic [N-1:0] s);
`ifdef ACCUM_RELU_EN
    return s[N-1] ? '0 : s;
`else
    return s;
`endif
  endfunction

  // Adder model: not touched by reset_n, overflow only rewritten by an add.
  always @(posedge clk) begin
    if (add_clr) a_sum <= '0;
    else if (add_en) {a_ovf, a_sum} <= sm_add(add_in1, add_in2);
    if (add_en) en_cnt <= en_cnt + 1;
  end

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pop and compare on every result handshake.
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        res_t r;
        r = exp_q.pop_front();
        chk("out_data", bus.out_data, r.data);
        chk("out_ovf", N'(bus.out_ovf), N'(r.ovf));
      end
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [N-1:0] raw, input logic o);
    res_t r;
    r.data = exp_out(raw); r.ovf = o;
    exp_q.push_back(r);
  endtask

  task automatic pulse_start(input logic [CNT_W-1:0] n);
    start = 1'b1; num_terms = n;
    step(1);
    start = 1'b0;
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [N-1:0] d);
    int t = 0;
    bus.in_valid = 1'b1; bus.in_data = d;
    while (!bus.in_ready && t < 50) begin step(1); t++; end
    if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
    step(1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 50) begin step(1); t++; end
    if (busy) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0;
    logic [N-1:0] held;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    step(3);
    chk("rst_in_ready", N'(bus.in_ready), 0);
    chk("rst_busy", N'(busy), 0);
    chk("rst_out_valid", N'(bus.out_valid), 0);
    chk("rst_out_data", bus.out_data, exp_out(a_sum));
    reset_n = 1'b1;
    step(1);

    // 1: three terms back to back, latency checks
    push_exp(32'h0003_8000, 1'b0);
    pulse_start(3);
    chk("t1_clr", N'(add_clr), 1);
    chk("t1_rdy_clear", N'(bus.in_ready), 0);
    step(1);
    chk("t1_rdy_2cyc", N'(bus.in_ready), 1);
    send(32'h0001_0000); send(32'h0002_0000); send(32'h0000_8000);
    chk("t1_valid_lat", N'(bus.out_valid), 1);
    chk("t1_rdy_done", N'(bus.in_ready), 0);
    wait_idle();

    // 2: gap of 3 idle cycles, exactly two adds
    e0 = en_cnt;
    push_exp(32'h0000_8000, 1'b0);
    pulse_start(2);
    send(32'h0001_0000);
    step(3);
    send(32'h8000_8000);
    wait_idle();
    chk("t2_add_en_cnt", N'(en_cnt - e0), 2);

    // 3: empty window
    push_exp(32'h0, 1'b0);
    pulse_start(0);
    chk("t3_clr", N'(add_clr), 1);
    step(1);
    chk("t3_done_valid", N'(bus.out_valid), 1);
    chk("t3_rdy", N'(bus.in_ready), 0);
    wait_idle();

    // 4: overflow window then a clean one
    push_exp(32'h7FFE_0000, 1'b1);
    pulse_start(2);
    send(32'h7FFF_0000); send(32'h7FFF_0000);
    wait_idle();
    push_exp(32'h0002_0000, 1'b0);
    pulse_start(2);
    send(32'h0001_0000); send(32'h0001_0000);
    wait_idle();

    // 5: back-pressure in DONE, start ignored
    bus.out_ready = 1'b0;
    push_exp(32'h0005_0000, 1'b0);
    pulse_start(1);
    send(32'h0005_0000);
    held = bus.out_data;
    for (int i = 0; i < 5; i++) begin
      chk("t5_valid_hold", N'(bus.out_valid), 1);
      chk("t5_data_stable", bus.out_data, held);
      if (i == 1) begin start = 1'b1; num_terms = 8'd7; end
      if (i == 2) start = 1'b0;
      step(1);
    end
    bus.out_ready = 1'b1;
    step(1);
    chk("t5_idle", N'(busy), 0);
    step(1);
    chk("t5_start_ignored", N'(busy), 0);
    chk("t5_no_clr", N'(add_clr), 0);

    // 6: reset mid-window
    pulse_start(4);
    send(32'h0001_0000);
    bus.in_valid = 1'b1; bus.in_data = 32'h0001_0000;
    #2 reset_n = 1'b0;
    #1;
    chk("t6_in_ready", N'(bus.in_ready), 0);
    chk("t6_add_en", N'(add_en), 0);
    chk("t6_add_clr", N'(add_clr), 0);
    chk("t6_out_valid", N'(bus.out_valid), 0);
    chk("t6_out_ovf", N'(bus.out_ovf), 0);
    chk("t6_busy", N'(busy), 0);
    bus.in_valid = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(1);
    push_exp(32'h0002_0000, 1'b0);
    pulse_start(2);
    send(32'h0001_0000); send(32'h0001_0000);
    wait_idle();

    // 7: negative window sum (clamped when ReLU is built in)
    push_exp(32'h8001_0000, 1'b0);
    pulse_start(2);
    send(32'h8001_0000); send(32'h0000_0000);
    wait_idle();

    // 8: maximum window length
    push_exp(32'h0000_00FF, 1'b0);
    pulse_start(8'd255);
    for (int i = 0; i < 255; i++) send(32'h0000_0001);
    chk("t8_rdy_done", N'(bus.in_ready), 0);
    wait_idle();

    step(2);
    chk("scoreboard_empty", N'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
